// File: rtl/system_setting_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : system_setting_bank_if
//  Description : Command/status bundle between the command decoder (master)
//                and the multi-channel setting bank (slave).
//                master drives : turn_on, turn_off, toggle, timed_mode,
//                                timeout, lock
//                slave drives  : out, changed, any_on
//  Revision    : 1.0 - initial release
// ============================================================================
interface system_setting_bank_if #(
  parameter int NUM_CH    = 8,
  parameter int TIMEOUT_W = 16
);
  logic [NUM_CH-1:0]    turn_on;
  logic [NUM_CH-1:0]    turn_off;
  logic [NUM_CH-1:0]    toggle;
  logic [NUM_CH-1:0]    timed_mode;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 lock;
  logic [NUM_CH-1:0]    out;
  logic [NUM_CH-1:0]    changed;
  logic                 any_on;

  modport master (
    output turn_on, turn_off, toggle, timed_mode, timeout, lock,
    input  out, changed, any_on
  );

  modport slave (
    input  turn_on, turn_off, toggle, timed_mode, timeout, lock,
    output out, changed, any_on
  );
endinterface
`default_nettype wire

// File: rtl/system_setting_bank.sv
`default_nettype none
// ============================================================================
//  Module      : system_setting_bank
//  Description : NUM_CH independent setting bits driven by on/off/toggle
//                strobes, each optionally auto-clearing after a shared
//                timeout (timed mode). A global lock masks on/toggle.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - system_setting_bank_if.slave
//                       (strobes, timed_mode, timeout, lock in;
//                        out, changed, any_on out)
//  Revision    : 1.0 - initial release
// ============================================================================
module system_setting_bank #(
  parameter int                NUM_CH    = 8,
  parameter int                TIMEOUT_W = 16,
  parameter logic [NUM_CH-1:0] RESET_VAL = '0
) (
  input  wire                   clk,
  input  wire                   rst,
  system_setting_bank_if.slave  bus
);

  localparam logic [TIMEOUT_W-1:0] C_ONE = TIMEOUT_W'(1);

  logic [NUM_CH-1:0]    out_q, out_d;
  logic [NUM_CH-1:0]    changed_q;
  logic                 any_on_q;
  logic [TIMEOUT_W-1:0] timer_q [NUM_CH];
  logic [TIMEOUT_W-1:0] timer_d [NUM_CH];

  // Per-channel next state. Priority: off > on > toggle > expiry.
  always_comb begin
    logic on_v;
    logic tg_v;
    logic exp_v;
    on_v  = 1'b0;
    tg_v  = 1'b0;
    exp_v = 1'b0;
    out_d = out_q;
    for (int i = 0; i < NUM_CH; i++) begin
      on_v  = bus.turn_on[i] & ~bus.lock;
      tg_v  = bus.toggle[i]  & ~bus.lock;
      // Expiry only while still in timed mode; a falling timed_mode latches.
      exp_v = bus.timed_mode[i] && (timer_q[i] == C_ONE);

      if (bus.turn_off[i])  out_d[i] = 1'b0;
      else if (on_v)        out_d[i] = 1'b1;
      else if (tg_v)        out_d[i] = ~out_q[i];
      else if (exp_v)       out_d[i] = 1'b0;
      else                  out_d[i] = out_q[i];

      if (!out_d[i] || !bus.timed_mode[i]) begin
        // Any clear, or leaving timed mode, idles the timer.
        timer_d[i] = '0;
      end else if (!out_q[i] || on_v) begin
        // Rising edge loads; turn_on on a set bit retriggers. A zero
        // timeout leaves the timer idle, so the channel simply latches.
        timer_d[i] = bus.timeout;
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - C_ONE;
      end else begin
        timer_d[i] = timer_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= RESET_VAL;
      changed_q <= '0;
      any_on_q  <= |RESET_VAL;
      for (int i = 0; i < NUM_CH; i++) timer_q[i] <= '0;
    end else begin
      out_q     <= out_d;
      changed_q <= out_d ^ out_q;
      any_on_q  <= |out_d;
      for (int i = 0; i < NUM_CH; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign bus.out     = out_q;
  assign bus.changed = changed_q;
  assign bus.any_on  = any_on_q;

endmodule
`default_nettype wire

// File: tb/tb_system_setting_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_setting_bank
//  Description : Directed scoreboard bench for system_setting_bank
//                (NUM_CH=8, TIMEOUT_W=16, RESET_VAL=8'h05).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_system_setting_bank;

  typedef struct {
    logic [7:0] out;
    logic [7:0] chg;
    logic       any;
    int         id;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   step_id;
  exp_t sb[$];

  system_setting_bank_if #(.NUM_CH(8), .TIMEOUT_W(16)) bus ();

  system_setting_bank #(
    .NUM_CH   (8),
    .TIMEOUT_W(16),
    .RESET_VAL(8'h05)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [7:0] ao,
                       input logic [7:0] ac, input logic aa, input logic [7:0] eo,
                       input logic [7:0] ec, input logic ea);
    total++;
    if (ao !== eo || ac !== ec || aa !== ea) begin
      bad++;
      $display("FAIL %s #%0d: got out=%h changed=%h any_on=%b, expected out=%h changed=%h any_on=%b",
               name, id, ao, ac, aa, eo, ec, ea);
    end
  endtask

  // Monitor: one expected entry is consumed per active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("step", e.id, bus.out, bus.changed, bus.any_on, e.out, e.chg, e.any);
      end
    end
  end

  // Drive strobes for one edge and queue the state expected right after it.
  task automatic step(input logic [7:0] on, input logic [7:0] off,
                      input logic [7:0] tg, input logic lk,
                      input logic [7:0] eo, input logic [7:0] ec);
    exp_t e;
    bus.turn_on  = on;
    bus.turn_off = off;
    bus.toggle   = tg;
    bus.lock     = lk;
    e.out = eo;
    e.chg = ec;
    e.any = |eo;
    e.id  = step_id;
    step_id++;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic lk, input logic [7:0] eo);
    for (int i = 0; i < n; i++) step(8'h00, 8'h00, 8'h00, lk, eo, 8'h00);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    step_id = 0;
    rst     = 1'b1;
    bus.turn_on    = '0;
    bus.turn_off   = '0;
    bus.toggle     = '0;
    bus.timed_mode = '0;
    bus.timeout    = 16'd5;
    bus.lock       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("reset", 0, bus.out, bus.changed, bus.any_on, 8'h05, 8'h00, 1'b1);
    rst = 1'b0;
    idle(20, 1'b0, 8'h05);

    // Basic set, repeated set
    step(8'h08, 8'h00, 8'h00, 1'b0, 8'h0D, 8'h08);
    idle(1, 1'b0, 8'h0D);
    step(8'h08, 8'h00, 8'h00, 1'b0, 8'h0D, 8'h00);

    // Priority: bit1 off beats on, bit4 on beats toggle, bit0 toggles
    step(8'h02, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h02);
    step(8'h12, 8'h02, 8'h11, 1'b0, 8'h1C, 8'h13);
    // Toggle a low bit then a high bit
    step(8'h00, 8'h00, 8'h20, 1'b0, 8'h3C, 8'h20);
    step(8'h00, 8'h00, 8'h20, 1'b0, 8'h1C, 8'h20);

    // Timed mode on bit6, timeout=5: high for exactly 5 edges
    bus.timed_mode = 8'h40;
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h5C, 8'h40);
    idle(4, 1'b0, 8'h5C);
    step(8'h00, 8'h00, 8'h00, 1'b0, 8'h1C, 8'h40);
    idle(1, 1'b0, 8'h1C);

    // Retrigger at k+3 -> clears at k+8
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h5C, 8'h40);
    idle(2, 1'b0, 8'h5C);
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h5C, 8'h00);
    idle(4, 1'b0, 8'h5C);
    step(8'h00, 8'h00, 8'h00, 1'b0, 8'h1C, 8'h40);

    // turn_on on the expiry edge keeps the bit high and reloads
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h5C, 8'h40);
    idle(4, 1'b0, 8'h5C);
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h5C, 8'h00);
    idle(4, 1'b0, 8'h5C);
    step(8'h00, 8'h00, 8'h00, 1'b0, 8'h1C, 8'h40);

    // Lock: on/toggle masked, off acts, timed channel still expires
    step(8'h01, 8'h00, 8'h00, 1'b0, 8'h1D, 8'h01);
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h5D, 8'h40);
    step(8'hFF, 8'h01, 8'hFF, 1'b1, 8'h5C, 8'h01);
    step(8'hFF, 8'h00, 8'hFF, 1'b1, 8'h5C, 8'h00);
    step(8'hFF, 8'h00, 8'hFF, 1'b1, 8'h5C, 8'h00);
    idle(1, 1'b1, 8'h5C);
    step(8'hFF, 8'h00, 8'h00, 1'b1, 8'h1C, 8'h40);
    // Unlock: commands act again
    step(8'h01, 8'h00, 8'h00, 1'b0, 8'h1D, 8'h01);
    step(8'h00, 8'h00, 8'h80, 1'b0, 8'h9D, 8'h80);

    // Asynchronous reset mid-timer
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'hDD, 8'h40);
    idle(1, 1'b0, 8'hDD);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", 1, bus.out, bus.changed, bus.any_on, 8'h05, 8'h00, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    // No expiry pulse after release; timers idle
    idle(8, 1'b0, 8'h05);
    step(8'h40, 8'h00, 8'h00, 1'b0, 8'h45, 8'h40);
    step(8'h00, 8'h40, 8'h00, 1'b0, 8'h05, 8'h40);
    idle(2, 1'b0, 8'h05);

    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
